// File: rtl/float_pkg.sv
// Shared types and format helpers for the parametrised floating-point adder.
package float_pkg;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fclass_e;

  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;

  localparam int MAX_W = 64;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_all1(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [MAX_W-1:0] v;
    v = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
    v = v | (MAX_W'(1) << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/float_lzc.sv
// Leading-zero counter; an all-zero input yields DATA_W.
module float_lzc #(
  parameter int DATA_W = 14,
  localparam int CNT_W = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] din,
  output logic [CNT_W-1:0]  cnt
);

  always_comb begin
    cnt = CNT_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (din[i]) cnt = CNT_W'(DATA_W - 1 - i);
    end
  end

endmodule

// File: rtl/float_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with RNE rounding,
// Inf/NaN handling, status flags and valid/ready backpressure.
module float_add_pipe
  import float_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int SW  = MAN_W + 3;
  localparam int NW  = MAN_W + 5;
  localparam int RW  = MAN_W + 2;
  localparam int LZW = $clog2(NW);
  localparam int XW  = EXP_W + LZW + 2;
  localparam logic [EXP_W-1:0] EXP_ALL1 = EXP_W'(fp_exp_all1(EXP_W));
  localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, MAN_W));

  function automatic fclass_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return CLS_ZERO;
    if (e == EXP_ALL1) return (m != '0) ? CLS_NAN : CLS_INF;
    return CLS_NORM;
  endfunction

  function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  function automatic logic [W+3:0] sat_pack(input logic sgn, input logic signed [XW-1:0] e,
                                            input logic [MAN_W-1:0] m, input logic inexact);
    logic [3:0] f;
    f = '0;
    if (e >= $signed({{(XW-EXP_W){1'b0}}, EXP_ALL1})) begin
      f[FLG_OVERFLOW] = 1'b1;
      f[FLG_INEXACT]  = 1'b1;
      return {sgn, EXP_ALL1, {MAN_W{1'b0}}, f};
    end
    if (e <= 0) begin
      f[FLG_UNDERFLOW] = 1'b1;
      f[FLG_INEXACT]   = 1'b1;
      return {{W{1'b0}}, f};
    end
    f[FLG_INEXACT] = inexact;
    return {sgn, e[EXP_W-1:0], m, f};
  endfunction

  logic vld_p0, vld_p1, vld_p2;
  logic ld_p0, ld_p1, ld_p2;

  assign ld_p2     = !vld_p2 || out_ready;
  assign ld_p1     = !vld_p1 || ld_p2;
  assign ld_p0     = !vld_p0 || ld_p1;
  assign in_ready  = ld_p0;
  assign out_valid = vld_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p0) vld_p0 <= in_valid;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // Stage 1: classify, order by magnitude, align the smaller operand
  logic            sgn_a, sgn_b, sgn_l, sgn_s, swap;
  fclass_e         cls_a, cls_b;
  logic [W-2:0]    mag_a, mag_b, mag_l, mag_s;
  logic [EXP_W-1:0] d;
  logic [31:0]     dsat;
  logic [SW-1:0]   ext_s, lost_s;
  logic            spc;
  logic [W-1:0]    spc_word;
  logic [3:0]      spc_flg;

  always_comb begin
    sgn_a = a[W-1];
    sgn_b = b[W-1] ^ op_sub;
    cls_a = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
    cls_b = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
    mag_a = (cls_a == CLS_ZERO) ? '0 : a[W-2:0];
    mag_b = (cls_b == CLS_ZERO) ? '0 : b[W-2:0];
    swap  = mag_b > mag_a;
    mag_l = swap ? mag_b : mag_a;
    mag_s = swap ? mag_a : mag_b;
    sgn_l = swap ? sgn_b : sgn_a;
    sgn_s = swap ? sgn_a : sgn_b;
    d     = mag_l[W-2:MAN_W] - mag_s[W-2:MAN_W];
    dsat  = (32'(d) > 32'(SW)) ? 32'(SW) : 32'(d);
    ext_s  = {|mag_s[W-2:MAN_W], mag_s[MAN_W-1:0], 2'b00};
    lost_s = ext_s << (32'(SW) - dsat);
    spc      = 1'b1;
    spc_word = '0;
    spc_flg  = '0;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_INF && cls_b == CLS_INF && sgn_a != sgn_b)) begin
      spc_word = QNAN;
      spc_flg[FLG_INVALID] = 1'b1;
    end else if (cls_a == CLS_INF) begin
      spc_word = {sgn_a, EXP_ALL1, {MAN_W{1'b0}}};
    end else if (cls_b == CLS_INF) begin
      spc_word = {sgn_b, EXP_ALL1, {MAN_W{1'b0}}};
    end else if (cls_a == CLS_ZERO && cls_b == CLS_ZERO) begin
      spc_word = {sgn_a & sgn_b, {(W-1){1'b0}}};
    end else begin
      spc = 1'b0;
    end
  end

  logic             sgn_l_p0, sgn_s_p0, stk_p0, spc_p0;
  logic [EXP_W-1:0] exp_p0;
  logic [MAN_W:0]   sig_l_p0;
  logic [SW-1:0]    sig_s_p0;
  logic [W-1:0]     spcw_p0;
  logic [3:0]       spcf_p0;

  always_ff @(posedge clk) begin
    if (ld_p0 && in_valid) begin
      sgn_l_p0 <= sgn_l;
      sgn_s_p0 <= sgn_s;
      exp_p0   <= mag_l[W-2:MAN_W];
      sig_l_p0 <= {|mag_l[W-2:MAN_W], mag_l[MAN_W-1:0]};
      sig_s_p0 <= ext_s >> dsat;
      stk_p0   <= |lost_s;
      spc_p0   <= spc;
      spcw_p0  <= spc_word;
      spcf_p0  <= spc_flg;
    end
  end

  // Stage 2: signed-magnitude add with carry, guard, round and sticky
  logic [NW-1:0] op_l, op_s, sum;

  always_comb begin
    op_l = {1'b0, sig_l_p0, 3'b000};
    op_s = {1'b0, sig_s_p0, stk_p0};
    sum  = (sgn_l_p0 ^ sgn_s_p0) ? op_l - op_s : op_l + op_s;
  end

  logic [NW-1:0]    sum_p1;
  logic [EXP_W-1:0] exp_p1;
  logic             sgn_p1, spc_p1;
  logic [W-1:0]     spcw_p1;
  logic [3:0]       spcf_p1;

  always_ff @(posedge clk) begin
    if (ld_p1 && vld_p0) begin
      sum_p1  <= sum;
      exp_p1  <= exp_p0;
      sgn_p1  <= sgn_l_p0;
      spc_p1  <= spc_p0;
      spcw_p1 <= spcw_p0;
      spcf_p1 <= spcf_p0;
    end
  end

  // Stage 3: normalise, round to nearest even, saturate and pack
  logic [LZW-1:0]         lz;
  logic [NW-2:0]          norm;
  logic signed [XW-1:0]   e_base, e_n, e_r;
  logic [RW-1:0]          rnd;
  logic [MAN_W-1:0]       man;
  logic                   inc;
  logic [W+3:0]           pk;

  float_lzc #(.DATA_W(NW - 1)) u_lzc (
    .din (sum_p1[NW-2:0]),
    .cnt (lz)
  );

  always_comb begin
    e_base = $signed({{(XW-EXP_W){1'b0}}, exp_p1});
    if (sum_p1[NW-1]) begin
      norm = {sum_p1[NW-1:2], |sum_p1[1:0]};
      e_n  = e_base + XW'(1);
    end else begin
      norm = sum_p1[NW-2:0] << lz;
      e_n  = e_base - $signed({{(XW-LZW){1'b0}}, lz});
    end
    inc = rne_inc(norm[3], norm[2], norm[1], norm[0]);
    rnd = {1'b0, norm[NW-2:3]} + RW'(inc);
    if (rnd[RW-1]) begin
      e_r = e_n + XW'(1);
      man = rnd[MAN_W:1];
    end else begin
      e_r = e_n;
      man = rnd[MAN_W-1:0];
    end
    if (spc_p1)            pk = {spcw_p1, spcf_p1};
    else if (sum_p1 == '0) pk = '0;
    else                   pk = sat_pack(sgn_p1, e_r, man, |norm[2:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      flags  <= '0;
    end else if (ld_p2 && vld_p1) begin
      result <= pk[W+3:4];
      flags  <= pk[3:0];
    end
  end

endmodule

// File: tb/tb_float_add_pipe.sv
// Directed bench for float_add_pipe: binary16 main instance plus a binary32 instance.
module tb_float_add_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic [3:0]  flags;

  logic        in_valid32, in_ready32, op_sub32, out_valid32, out_ready32;
  logic [31:0] a32, b32, result32;
  logic [3:0]  flags32;

  int checks = 0;
  int errors = 0;

  float_add_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  float_add_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .op_sub(op_sub32), .out_valid(out_valid32), .out_ready(out_ready32),
    .result(result32), .flags(flags32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation through an empty pipeline, with latency measured in cycles.
  task automatic single(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic sub, input logic [15:0] er, input logic [3:0] ef);
    int cyc;
    @(negedge clk);
    a = ta; b = tbv; op_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 20);
    check({tag, "_lat"}, 32'(cyc), 32'd3);
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_flg"}, 32'(flags), 32'(ef));
  endtask

  logic [15:0] st_a[8], st_b[8], st_r[8];
  logic        st_sub[8];
  int          st_n;

  task automatic set_item(input int i, input logic [15:0] ta, input logic [15:0] tbv,
                          input logic sub, input logic [15:0] er);
    st_a[i] = ta; st_b[i] = tbv; st_sub[i] = sub; st_r[i] = er;
  endtask

  // Streams st_n items; out_ready held low for the first 'stall' cycles.
  task automatic stream(input string tag, input int stall, output int acc, output int stall_bad,
                        output int nout, output int rdy_bad);
    int ii, oi, cyc;
    ii = 0; oi = 0; cyc = 0; acc = 0; stall_bad = 0; rdy_bad = 0;
    while (oi < st_n && cyc < 100) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      in_valid  = (ii < st_n);
      if (ii < st_n) begin
        a = st_a[ii]; b = st_b[ii]; op_sub = st_sub[ii];
      end
      #1;
      if (cyc >= 3 && cyc < stall && in_ready) rdy_bad++;
      if (out_valid && !out_ready && result !== st_r[oi]) stall_bad++;
      if (out_valid && out_ready) begin
        check({tag, "_out"}, 32'(result), 32'(st_r[oi]));
        oi++;
      end
      if (in_valid && in_ready) ii++;
      if (cyc == stall - 1) acc = ii;
      cyc++;
    end
    nout = oi;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int acc, sbad, nout, rbad, seen, cyc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_sub = 1'b0; a = '0; b = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; op_sub32 = 1'b0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_flags",     32'(flags),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b0;

    single("add_basic",  16'h3E00, 16'h3800, 1'b0, 16'h4000, 4'h0);
    single("cancel",     16'h4200, 16'h4200, 1'b1, 16'h0000, 4'h0);
    single("tie_even",   16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'h1);
    single("round_up",   16'h3C00, 16'h1200, 1'b0, 16'h3C01, 4'h1);
    single("overflow",   16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5);
    single("inf_m_inf",  16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'h8);
    single("nan_in",     16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'h8);
    single("inf_p_fin",  16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'h0);
    single("negzero",    16'h8000, 16'h8000, 1'b0, 16'h8000, 4'h0);
    single("sub_norm",   16'h3C00, 16'h3800, 1'b1, 16'h3800, 4'h0);
    single("underflow",  16'h0600, 16'h0400, 1'b1, 16'h0000, 4'h3);

    // Backpressure: five identical pairs against a six-cycle stall
    for (int i = 0; i < 5; i++) set_item(i, 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
    st_n = 5;
    stream("bp", 6, acc, sbad, nout, rbad);
    check("bp_accepted",  32'(acc),  32'd3);
    check("bp_in_ready",  32'(rbad), 32'd0);
    check("bp_stable",    32'(sbad), 32'd0);
    check("bp_count",     32'(nout), 32'd5);

    // Ordering with distinct results and a short stall
    set_item(0, 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
    set_item(1, 16'h4000, 16'h3C00, 1'b0, 16'h4200);
    set_item(2, 16'h4000, 16'h4000, 1'b0, 16'h4400);
    set_item(3, 16'h4400, 16'h3C00, 1'b0, 16'h4500);
    set_item(4, 16'h3C00, 16'h3800, 1'b1, 16'h3800);
    st_n = 5;
    stream("ord", 2, acc, sbad, nout, rbad);
    check("ord_stable", 32'(sbad), 32'd0);
    check("ord_count",  32'(nout), 32'd5);

    // Reset with two pairs in flight
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h3C00; b = 16'h3C00; op_sub = 1'b0;
    @(negedge clk);
    a = 16'h4000; b = 16'h4000;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("midrst_valid",  32'(out_valid), 32'd0);
    check("midrst_result", 32'(result),    32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_stale", 32'(seen), 32'd0);

    // Binary32 instance
    @(negedge clk);
    a32 = 32'h3FC00000; b32 = 32'h3F000000; op_sub32 = 1'b0; in_valid32 = 1'b1;
    @(posedge clk);
    #1 in_valid32 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid32 && cyc < 20);
    check("f32_lat",    32'(cyc),     32'd3);
    check("f32_result", result32,     32'h40000000);
    check("f32_flags",  32'(flags32), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_add_pipe.md
Name: float_add_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor for the CNN datapath; default format is binary16, matching the existing combinational half-precision adder.
- Sits between the MAC accumulator and the activation stage.
- Adds over the previous generation:
  - configurable exponent and mantissa widths
  - add/subtract mode
  - round-to-nearest-even
  - Inf/NaN handling and status flags
  - 3-stage valid/ready pipeline with backpressure

Parameters:
EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 10, stored mantissa width (hidden bit implied)
W, 1+EXP_W+MAN_W, total word width (derived, not overridable)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
a  in  W  operand A
b  in  W  operand B
op_sub  in  1  0: A+B, 1: A-B (B sign inverted at capture)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  W  rounded sum
flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Interface: one clock `clk`; synchronous active-high reset `reset`.
- Reset:
  - All stage-valid bits clear, so out_valid=0 the cycle after reset is sampled.
  - result=0 and flags=0 on reset.
  - In-flight data is discarded; mid-operation reset loses it silently.
- Handshake:
  - A transfer occurs when valid&&ready.
  - Each stage register loads when it is empty or its downstream stage advances.
  - in_ready = !s1_valid || s1_advance, so it is combinationally dependent on out_ready.
  - result and flags stay stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - Latency is 3 cycles from input transfer to out_valid.
  - Throughput is 1 per cycle when out_ready is held high.
  - Order is strictly preserved.
- S1, unpack/align:
  - Swap operands so the larger magnitude is first.
  - Shift the smaller mantissa right by the exponent difference, saturated at MAN_W+3.
  - Keep guard, round and sticky bits; sticky is the OR of all bits shifted out.
  - Classify each operand as zero, normal, Inf or NaN.
  - exp==0 is treated as zero: subnormals are flushed to zero on input.
- S2, add:
  - Effective subtract when signs differ after op_sub.
  - Mantissa width is MAN_W+5: carry, hidden, mantissa, G, R, S.
  - Result sign is the sign of the larger-magnitude operand.
  - Exact cancellation gives +0.
- S3, normalise/round/pack:
  - On carry-out, shift right by 1 and increment the exponent (sticky is preserved).
  - Otherwise apply a leading-zero count and shift left, decrementing the exponent.
  - Rounding is RNE: increment when G && (R||S||lsb).
  - A rounding carry renormalises.
  - inexact = G|R|S before rounding.
- Boundaries:
  - Exponent ≥ all-ones: result is ±Inf (mantissa 0), with overflow=1 and inexact=1.
  - Exponent ≤ 0: result is +0, with underflow=1 and inexact=1.
  - Any NaN input, or Inf-Inf with effective subtract: canonical quiet NaN (sign 0, exp all-ones, mantissa MSB=1), with invalid=1.
  - Inf plus finite operand: that Inf, with no flags.
  - Both operands zero: +0, except that (-0)+(-0) gives -0.

Decomposition:
- Package float_pkg holds:
  - function localparams for the bias and the EXP_ALL1 exponent value
  - class enum {ZERO, NORM, INF, NAN}
  - the flag bit indices
  - the canonical-NaN constant as a function of EXP_W/MAN_W
- One sub-module, float_lzc: parametrised leading-zero counter used in S3.

Test Plan:
- Basic add, binary16, out_ready=1: a=0x3E00 (1.5), b=0x3800 (0.5), op_sub=0 -> result=0x4000 exactly 3 cycles later, flags=0.
- Subtract with exact cancellation: a=0x4200, b=0x4200, op_sub=1 -> result=0x0000, flags=0.
- Rounding:
  - a=0x3C00, b=0x1000 -> 0x3C00 (tie to even), inexact=1.
  - a=0x3C00, b=0x1200 -> 0x3C01, inexact=1.
- Overflow and invalid:
  - 0x7BFF+0x7BFF -> 0x7C00 with overflow and inexact set.
  - 0x7C00 minus 0x7C00 (op_sub=1) -> 0x7E00 with invalid set.
- Backpressure:
  - Stimulus: stream 5 back-to-back pairs, each 0x3C00+0x3C00; hold out_ready=0 for 6 cycles, then release.
  - During the stall: in_ready drops after 3 pairs are accepted, and result stays 0x4000 and stable.
  - After release: all 5 outputs appear in order with none lost or duplicated.
- Reset mid-stream and non-default width:
  - Assert reset with 2 pairs in flight -> out_valid=0 the next cycle and no stale result afterwards.
  - Repeat the basic add with EXP_W=8, MAN_W=23: 0x3FC00000 + 0x3F000000 -> 0x40000000.
